cga_mac_segpt_rdbk: RTL and testbench

Readback sequencer for the MAC segment/page-table control registers (PCR, SEG, EXM status). It serves register-read requests from the microcode sequencer over a request/acknowledge handshake. It snapshots the selected register into a holding register and drives it onto the internal readback bus FIDBI for a programmable number of cycles. It sits beside the SEGPT register block in CGA/MAC and is the read-side counterpart of that block's FIDBO load path.

---
 rtl/cga_mac_segpt_rdbk.sv | 136 +++++++++++++
 tb/tb_cga_mac_segpt_rdbk.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cga_mac_segpt_rdbk.sv
// Readback sequencer for MAC SEGPT registers: snapshot PCR/SEG/EXM into a holding register and
// drive it on FIDBI for DRV_CYCLES cycles. Optional FIDBIPAR output via CGA_MAC_RDBK_PARITY_EN.
module cga_mac_segpt_rdbk #(
    parameter int unsigned DRV_CYCLES = 2
) (
    input  logic        MCLK,
    input  logic        RESETN,
    input  logic        RDREQ,
    input  logic [1:0]  RSEL,
    input  logic [15:0] PCR_15_7_2_0,
    input  logic [7:0]  SEG_7_0,
    input  logic        PEX,
    input  logic        VEX,
    input  logic [1:0]  XPT_1_0,
    output logic [15:0] FIDBI_15_0,
    output logic        FIDBIEN,
    output logic        RDACK,
    output logic        RDERR,
`ifdef CGA_MAC_RDBK_PARITY_EN
    output logic        FIDBIPAR,
`endif
    output logic        BUSY
);

    typedef enum logic [1:0] {StIdle, StCapt, StDrive} state_e;

    localparam logic [3:0] CntInit = 4'(DRV_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  rsel_q, rsel_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] fidbi_q, fidbi_d;
    logic        drive_q, drive_d;
    logic        rdack_q, rdack_d;
    logic        rderr_q, rderr_d;
    logic        busy_q, busy_d;
    logic [15:0] word;
    logic        unused_pcr;

    // PCR bits 6:3 carry no architectural state and read back as zero.
    assign unused_pcr = ^PCR_15_7_2_0[6:3];

    always_comb begin
        word = 16'h0000;
        case (rsel_q)
            2'd0:    word = {PCR_15_7_2_0[15:7], 4'b0000, PCR_15_7_2_0[2:0]};
            2'd1:    word = {8'h00, SEG_7_0};
            2'd2:    word = {12'h000, PEX, VEX, XPT_1_0};
            default: word = 16'h0000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rsel_d  = rsel_q;
        hold_d  = hold_q;
        case (state_q)
            StIdle: begin
                if (RDREQ) begin
                    rsel_d  = RSEL;
                    state_d = StCapt;
                end
            end
            StCapt: begin
                hold_d  = word;
                cnt_d   = CntInit;
                state_d = StDrive;
            end
            StDrive: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so they are computed from the next state.
        drive_d = (state_d == StDrive);
        fidbi_d = drive_d ? hold_d : 16'h0000;
        rdack_d = drive_d && (cnt_d == 4'd0);
        rderr_d = rdack_d && (rsel_q == 2'd3);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge MCLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rsel_q  <= 2'd0;
            hold_q  <= 16'h0000;
            fidbi_q <= 16'h0000;
            drive_q <= 1'b0;
            rdack_q <= 1'b0;
            rderr_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rsel_q  <= rsel_d;
            hold_q  <= hold_d;
            fidbi_q <= fidbi_d;
            drive_q <= drive_d;
            rdack_q <= rdack_d;
            rderr_q <= rderr_d;
            busy_q  <= busy_d;
        end
    end

    assign FIDBI_15_0 = fidbi_q;
    assign FIDBIEN    = drive_q;
    assign RDACK      = rdack_q;
    assign RDERR      = rderr_q;
    assign BUSY       = busy_q;

`ifdef CGA_MAC_RDBK_PARITY_EN
    logic par_q, par_d;

    // Odd parity: the 17-bit {FIDBIPAR, FIDBI} word has an odd number of ones.
    assign par_d = drive_d ? ~(^hold_d) : 1'b0;

    always_ff @(posedge MCLK or negedge RESETN) begin
        if (!RESETN) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign FIDBIPAR = par_q;
`endif

endmodule

// File: tb/tb_cga_mac_segpt_rdbk.sv
// Self-checking bench for cga_mac_segpt_rdbk (DRV_CYCLES=2): vector table, snapshot,
// back-to-back request and mid-read reset sequences, with a readback scoreboard.
module tb_cga_mac_segpt_rdbk;

    logic        MCLK = 1'b0;
    logic        RESETN;
    logic        RDREQ;
    logic [1:0]  RSEL;
    logic [15:0] PCR_15_7_2_0;
    logic [7:0]  SEG_7_0;
    logic        PEX;
    logic        VEX;
    logic [1:0]  XPT_1_0;
    logic [15:0] FIDBI_15_0;
    logic        FIDBIEN;
    logic        RDACK;
    logic        RDERR;
    logic        BUSY;
`ifdef CGA_MAC_RDBK_PARITY_EN
    logic        FIDBIPAR;
`endif

    cga_mac_segpt_rdbk #(.DRV_CYCLES(2)) dut (
        .MCLK         (MCLK),
        .RESETN       (RESETN),
        .RDREQ        (RDREQ),
        .RSEL         (RSEL),
        .PCR_15_7_2_0 (PCR_15_7_2_0),
        .SEG_7_0      (SEG_7_0),
        .PEX          (PEX),
        .VEX          (VEX),
        .XPT_1_0      (XPT_1_0),
        .FIDBI_15_0   (FIDBI_15_0),
        .FIDBIEN      (FIDBIEN),
        .RDACK        (RDACK),
        .RDERR        (RDERR),
`ifdef CGA_MAC_RDBK_PARITY_EN
        .FIDBIPAR     (FIDBIPAR),
`endif
        .BUSY         (BUSY)
    );

    always #5 MCLK = ~MCLK;

    typedef struct {
        logic [1:0]  rsel;
        logic [15:0] pcr;
        logic [7:0]  seg;
        logic        pex;
        logic        vex;
        logic [1:0]  xpt;
        logic [15:0] exp_word;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [15:0] word;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Scoreboard: every completion pulse retires one expected readback.
    always @(negedge MCLK) begin
        if (RESETN === 1'b1 && RDACK === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_ack", 32'(RDACK), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_data", 32'(FIDBI_15_0), 32'(e.word));
                chk("sb_err", 32'(RDERR), 32'(e.err));
            end
        end
    end

    // chg: 0 none, 1 change SEG during CAPT, 2 change SEG during first DRIVE cycle.
    task automatic do_read(input vec_t v, input int chg, input logic [7:0] seg_new);
        exp_t e;
        @(negedge MCLK);
        RSEL = v.rsel; PCR_15_7_2_0 = v.pcr; SEG_7_0 = v.seg;
        PEX = v.pex; VEX = v.vex; XPT_1_0 = v.xpt;
        RDREQ = 1'b1;
        @(posedge MCLK);
        #1;
        RDREQ = 1'b0;
        RSEL  = ~v.rsel;
        e.word = v.exp_word; e.err = v.exp_err;
        sb_q.push_back(e);
        if (chg == 1) SEG_7_0 = seg_new;
        @(negedge MCLK);
        chk("capt_busy", 32'(BUSY), 32'd1);
        chk("capt_en", 32'(FIDBIEN), 32'd0);
        chk("capt_data", 32'(FIDBI_15_0), 32'd0);
        @(posedge MCLK);
        #1;
        if (chg == 2) SEG_7_0 = seg_new;
        @(negedge MCLK);
        chk("drv1_en", 32'(FIDBIEN), 32'd1);
        chk("drv1_data", 32'(FIDBI_15_0), 32'(v.exp_word));
        chk("drv1_ack", 32'(RDACK), 32'd0);
        @(negedge MCLK);
        chk("drv2_en", 32'(FIDBIEN), 32'd1);
        chk("drv2_data", 32'(FIDBI_15_0), 32'(v.exp_word));
        chk("drv2_ack", 32'(RDACK), 32'd1);
`ifdef CGA_MAC_RDBK_PARITY_EN
        chk("drv2_par", 32'(FIDBIPAR), 32'(~(^v.exp_word)));
`endif
        @(negedge MCLK);
        chk("done_busy", 32'(BUSY), 32'd0);
        chk("done_en", 32'(FIDBIEN), 32'd0);
        chk("done_data", 32'(FIDBI_15_0), 32'd0);
        chk("done_ack", 32'(RDACK), 32'd0);
`ifdef CGA_MAC_RDBK_PARITY_EN
        chk("done_par", 32'(FIDBIPAR), 32'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[8];
        vec_t v;
        exp_t e;
        vecs[0] = '{2'd0, 16'hFFFF, 8'h00, 1'b0, 1'b0, 2'b00, 16'hFF87, 1'b0};
        vecs[1] = '{2'd0, 16'h1234, 8'hFF, 1'b1, 1'b1, 2'b11, 16'h1204, 1'b0};
        vecs[2] = '{2'd1, 16'hFFFF, 8'hA5, 1'b1, 1'b1, 2'b11, 16'h00A5, 1'b0};
        vecs[3] = '{2'd2, 16'hFFFF, 8'hFF, 1'b1, 1'b0, 2'b11, 16'h000B, 1'b0};
        vecs[4] = '{2'd2, 16'h0000, 8'h00, 1'b0, 1'b1, 2'b01, 16'h0005, 1'b0};
        vecs[5] = '{2'd3, 16'hFFFF, 8'hFF, 1'b1, 1'b1, 2'b11, 16'h0000, 1'b1};
        vecs[6] = '{2'd0, 16'h0001, 8'h00, 1'b0, 1'b0, 2'b00, 16'h0001, 1'b0};
        vecs[7] = '{2'd1, 16'h0000, 8'h03, 1'b0, 1'b0, 2'b00, 16'h0003, 1'b0};

        RESETN = 1'b0; RDREQ = 1'b0; RSEL = 2'd0; PCR_15_7_2_0 = 16'h0000;
        SEG_7_0 = 8'h00; PEX = 1'b0; VEX = 1'b0; XPT_1_0 = 2'b00;
        repeat (2) @(negedge MCLK);
        chk("rst_data", 32'(FIDBI_15_0), 32'd0);
        chk("rst_en", 32'(FIDBIEN), 32'd0);
        chk("rst_ack", 32'(RDACK), 32'd0);
        chk("rst_err", 32'(RDERR), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        RESETN = 1'b1;

        for (int i = 0; i < 8; i++) do_read(vecs[i], 0, 8'h00);

        // Snapshot taken at the CAPT->DRIVE edge.
        v = '{2'd1, 16'h0000, 8'h11, 1'b0, 1'b0, 2'b00, 16'h0022, 1'b0};
        do_read(v, 1, 8'h22);
        v = '{2'd1, 16'h0000, 8'h11, 1'b0, 1'b0, 2'b00, 16'h0011, 1'b0};
        do_read(v, 2, 8'h22);

        // RDREQ held high: one accepted read every 4 cycles.
        @(negedge MCLK);
        RSEL = 2'd1; SEG_7_0 = 8'h5A; RDREQ = 1'b1;
        e.word = 16'h005A; e.err = 1'b0;
        repeat (3) sb_q.push_back(e);
        for (int k = 0; k < 12; k++) begin
            @(negedge MCLK);
            chk("held_busy", 32'(BUSY), 32'((k % 4) != 3));
            chk("held_ack", 32'(RDACK), 32'((k % 4) == 2));
        end
        RDREQ = 1'b0;
        repeat (2) @(negedge MCLK);
        chk("held_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset in the first DRIVE cycle aborts the read with no completion.
        @(negedge MCLK);
        RSEL = 2'd0; PCR_15_7_2_0 = 16'hFFFF; RDREQ = 1'b1;
        @(posedge MCLK);
        #1;
        RDREQ = 1'b0;
        @(negedge MCLK);
        @(negedge MCLK);
        chk("abort_pre_en", 32'(FIDBIEN), 32'd1);
        #1;
        RESETN = 1'b0;
        #1;
        chk("abort_data", 32'(FIDBI_15_0), 32'd0);
        chk("abort_en", 32'(FIDBIEN), 32'd0);
        chk("abort_ack", 32'(RDACK), 32'd0);
        chk("abort_err", 32'(RDERR), 32'd0);
        chk("abort_busy", 32'(BUSY), 32'd0);
        @(negedge MCLK);
        RESETN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge MCLK);
            chk("abort_no_ack", 32'(RDACK), 32'd0);
            chk("abort_idle", 32'(BUSY), 32'd0);
        end
        do_read(vecs[0], 0, 8'h00);

        @(negedge MCLK);
        chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
